// File: rtl/kira_pc_pkg.sv
// Shared definitions for the KIRA fetch-stage PC sequencer and its hardware-loop slots.
package kira_pc_pkg;

  localparam int unsigned PC_INC = 4;
  localparam logic [31:0] DEF_RESET_PC   = 32'h4000_0000;
  localparam logic [31:0] DEF_PRELOAD_PC = 32'h0000_0800;

  typedef struct packed {
    logic [31:0] start_pc;
    logic [31:0] end_pc;
    logic [15:0] count;
  } lp_slot_t;

endpackage

// File: rtl/pc_sequencer_hwloop_slot.sv
// One zero-overhead hardware-loop slot: start/end/count registers plus hit/last flags for the scan.
module hwloop_slot
  import kira_pc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_dec,
  input  logic             i_exit,
  input  logic             i_wr,
  input  logic [XLEN-1:0]  i_wr_start,
  input  logic [XLEN-1:0]  i_wr_end,
  input  logic [CNT_W-1:0] i_wr_count,
  output logic             o_hit,
  output logic             o_last,
  output logic             o_active,
  output logic [XLEN-1:0]  o_start
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0]  r_start;
  logic [XLEN-1:0]  r_end;
  logic [CNT_W-1:0] r_count;
  logic             r_active;

  // Slot state: reset/clear beat a write, and a write beats the scan's decrement or exit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_start  <= {XLEN{1'b0}};
      r_end    <= {XLEN{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_active <= 1'b0;
    end else if (i_clr) begin
      r_count  <= {CNT_W{1'b0}};
      r_active <= 1'b0;
    end else if (i_wr) begin
      r_start  <= i_wr_start & ALIGN_MASK;
      r_end    <= i_wr_end & ALIGN_MASK;
      r_count  <= i_wr_count;
      r_active <= (i_wr_count != {CNT_W{1'b0}});
    end else if (i_dec) begin
      r_count  <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
      r_active <= 1'b1;
    end else if (i_exit) begin
      r_count  <= {CNT_W{1'b0}};
      r_active <= 1'b0;
    end else begin
      r_count  <= r_count;
      r_active <= r_active;
    end
  end

  assign o_hit    = r_active && (r_end == i_pc);
  assign o_last   = (r_count == {{(CNT_W-1){1'b0}}, 1'b1});
  assign o_active = r_active;
  assign o_start  = r_start;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with next-PC priority (reset, preload, stall, redirect, loop back-edge, +4)
// and a slot-0-first scan over LOOPS hardware-loop slots.
module pc_sequencer
  import kira_pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
  parameter logic [XLEN-1:0] PRELOAD_PC = XLEN'(DEF_PRELOAD_PC),
  parameter int              LOOPS      = 2,
  parameter int              CNT_W      = 16,
  parameter int              IDX_W      = (LOOPS > 1) ? $clog2(LOOPS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ena,
  input  logic             i_preload,
  input  logic             i_redirect_valid,
  input  logic [XLEN-1:0]  i_redirect_pc,
  input  logic             i_lp_wr_valid,
  input  logic [IDX_W-1:0] i_lp_wr_idx,
  input  logic [XLEN-1:0]  i_lp_wr_start,
  input  logic [XLEN-1:0]  i_lp_wr_end,
  input  logic [CNT_W-1:0] i_lp_wr_count,
  output logic [XLEN-1:0]  o_pc,
  output logic [LOOPS-1:0] o_lp_active,
  output logic             o_lp_back,
  output logic [LOOPS-1:0] o_lp_done
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [XLEN-1:0]  r_pc;
  logic             r_lp_back;
  logic [LOOPS-1:0] r_lp_done;

  logic [LOOPS-1:0] w_hit;
  logic [LOOPS-1:0] w_last;
  logic [LOOPS-1:0] w_active;
  logic [LOOPS-1:0] w_wr;
  logic [LOOPS-1:0] w_dec;
  logic [LOOPS-1:0] w_exit;
  logic [XLEN-1:0]  w_start [LOOPS];
  logic             w_resolve;
  logic             w_found;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_next_pc;

  assign w_resolve = i_rst_n && !i_preload && i_ena && !i_redirect_valid;

  for (genvar g = 0; g < LOOPS; g++) begin : g_slot
    assign w_wr[g] = i_lp_wr_valid && (i_lp_wr_idx == IDX_W'(g));

    hwloop_slot #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
    ) u_slot (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clr      (i_preload),
      .i_pc       (r_pc),
      .i_dec      (w_dec[g]),
      .i_exit     (w_exit[g]),
      .i_wr       (w_wr[g]),
      .i_wr_start (i_lp_wr_start),
      .i_wr_end   (i_lp_wr_end),
      .i_wr_count (i_lp_wr_count),
      .o_hit      (w_hit[g]),
      .o_last     (w_last[g]),
      .o_active   (w_active[g]),
      .o_start    (w_start[g])
    );
  end

  // Back-edge scan: final-iteration slots exit and fall through so nested loops can share an end.
  always_comb begin
    w_dec    = {LOOPS{1'b0}};
    w_exit   = {LOOPS{1'b0}};
    w_found  = 1'b0;
    w_target = r_pc;
    for (int i = 0; i < LOOPS; i++) begin
      if (w_resolve && !w_found && w_hit[i]) begin
        if (w_last[i]) begin
          w_exit[i] = 1'b1;
        end else begin
          w_dec[i] = 1'b1;
          w_found  = 1'b1;
          w_target = w_start[i];
        end
      end else begin
        w_dec[i] = 1'b0;
      end
    end
  end

  // Next-PC priority mux below reset.
  always_comb begin
    w_next_pc = r_pc;
    if (i_preload) begin
      w_next_pc = PRELOAD_PC;
    end else if (!i_ena) begin
      w_next_pc = r_pc;
    end else if (i_redirect_valid) begin
      w_next_pc = i_redirect_pc & ALIGN_MASK;
    end else if (w_found) begin
      w_next_pc = w_target;
    end else begin
      w_next_pc = r_pc + XLEN'(PC_INC);
    end
  end

  // PC and pulse registers; pulses are tied to the same edge as the PC update they describe.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc      <= RESET_PC;
      r_lp_back <= 1'b0;
      r_lp_done <= {LOOPS{1'b0}};
    end else begin
      r_pc      <= w_next_pc;
      r_lp_back <= w_found;
      r_lp_done <= w_exit;
    end
  end

  assign o_pc        = r_pc;
  assign o_lp_active = w_active;
  assign o_lp_back   = r_lp_back;
  assign o_lp_done   = r_lp_done;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus hand-written stall/override/preload/reset sequences.
module tb_pc_sequencer;

  localparam logic [31:0] B = 32'h4000_0000;

  typedef struct packed {
    logic        rst_n;
    logic        ena;
    logic        pre;
    logic        rv;
    logic [31:0] rpc;
    logic        wv;
    logic        widx;
    logic [31:0] ws;
    logic [31:0] we;
    logic [15:0] wc;
    logic [31:0] epc;
    logic [1:0]  eact;
    logic        eback;
    logic [1:0]  edone;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        preload;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        lp_wr_valid;
  logic [0:0]  lp_wr_idx;
  logic [31:0] lp_wr_start;
  logic [31:0] lp_wr_end;
  logic [15:0] lp_wr_count;
  logic [31:0] pc;
  logic [1:0]  lp_active;
  logic        lp_back;
  logic [1:0]  lp_done;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tbl[$];

  pc_sequencer dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_ena            (ena),
    .i_preload        (preload),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_lp_wr_valid    (lp_wr_valid),
    .i_lp_wr_idx      (lp_wr_idx),
    .i_lp_wr_start    (lp_wr_start),
    .i_lp_wr_end      (lp_wr_end),
    .i_lp_wr_count    (lp_wr_count),
    .o_pc             (pc),
    .o_lp_active      (lp_active),
    .o_lp_back        (lp_back),
    .o_lp_done        (lp_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic e, logic p, logic rv, logic [31:0] rpc,
                              logic wv, logic wi, logic [31:0] ws, logic [31:0] we,
                              logic [15:0] wc, logic [31:0] epc, logic [1:0] eact,
                              logic eb, logic [1:0] ed);
    vec_t v;
    v = '{r, e, p, rv, rpc, wv, wi, ws, we, wc, epc, eact, eb, ed};
    return v;
  endfunction

  function automatic vec_t sq(logic [31:0] epc, logic [1:0] eact, logic eb, logic [1:0] ed);
    return mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, epc, eact, eb, ed);
  endfunction

  function automatic vec_t wr(logic e, logic wi, logic [31:0] ws, logic [31:0] we, logic [15:0] wc,
                              logic [31:0] epc, logic [1:0] eact, logic eb);
    return mk(1'b1, e, 1'b0, 1'b0, 32'h0, 1'b1, wi, ws, we, wc, epc, eact, eb, 2'b00);
  endfunction

  function automatic vec_t rd(logic [31:0] rpc, logic [31:0] epc, logic [1:0] eact);
    return mk(1'b1, 1'b1, 1'b0, 1'b1, rpc, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, epc, eact, 1'b0, 2'b00);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    rst_n          = v.rst_n;
    ena            = v.ena;
    preload        = v.pre;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    lp_wr_valid    = v.wv;
    lp_wr_idx      = v.widx;
    lp_wr_start    = v.ws;
    lp_wr_end      = v.we;
    lp_wr_count    = v.wc;
    @(posedge clk);
    #1;
    chk({tag, " pc"},     pc,                v.epc);
    chk({tag, " active"}, {30'd0, lp_active}, {30'd0, v.eact});
    chk({tag, " back"},   {31'd0, lp_back},   {31'd0, v.eback});
    chk({tag, " done"},   {30'd0, lp_done},   {30'd0, v.edone});
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; preload = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    lp_wr_valid = 1'b0; lp_wr_idx = 1'b0; lp_wr_start = 32'h0; lp_wr_end = 32'h0;
    lp_wr_count = 16'h0;

    // Reset and sequential fetch
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, B, 2'b00, 1'b0, 2'b00));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, B, 2'b00, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h04, 2'b00, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h08, 2'b00, 1'b0, 2'b00));
    // Single loop, 3 iterations
    tbl.push_back(wr(1'b1, 1'b0, B + 32'h10, B + 32'h18, 16'd3, B + 32'h0C, 2'b01, 1'b0));
    tbl.push_back(sq(B + 32'h10, 2'b01, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h14, 2'b01, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h18, 2'b01, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h10, 2'b01, 1'b1, 2'b00));
    tbl.push_back(sq(B + 32'h14, 2'b01, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h18, 2'b01, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h10, 2'b01, 1'b1, 2'b00));
    tbl.push_back(sq(B + 32'h14, 2'b01, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h18, 2'b01, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h1C, 2'b00, 1'b0, 2'b01));
    // Nested loops sharing end 0x4000_0028
    tbl.push_back(wr(1'b1, 1'b1, B + 32'h10, B + 32'h28, 16'd2, B + 32'h20, 2'b10, 1'b0));
    tbl.push_back(wr(1'b1, 1'b0, B + 32'h20, B + 32'h28, 16'd2, B + 32'h24, 2'b11, 1'b0));
    tbl.push_back(sq(B + 32'h28, 2'b11, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h20, 2'b11, 1'b1, 2'b00));
    tbl.push_back(sq(B + 32'h24, 2'b11, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h28, 2'b11, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h10, 2'b10, 1'b1, 2'b01));
    tbl.push_back(wr(1'b1, 1'b0, B + 32'h20, B + 32'h28, 16'd2, B + 32'h14, 2'b11, 1'b0));
    tbl.push_back(sq(B + 32'h18, 2'b11, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h1C, 2'b11, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h20, 2'b11, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h24, 2'b11, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h28, 2'b11, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h20, 2'b11, 1'b1, 2'b00));
    tbl.push_back(sq(B + 32'h24, 2'b11, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h28, 2'b11, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h2C, 2'b00, 1'b0, 2'b11));
    // Redirect at an active loop end leaves the count alone
    tbl.push_back(wr(1'b1, 1'b0, B + 32'h30, B + 32'h34, 16'd3, B + 32'h30, 2'b01, 1'b0));
    tbl.push_back(sq(B + 32'h34, 2'b01, 1'b0, 2'b00));
    tbl.push_back(rd(B + 32'h103, B + 32'h100, 2'b01));
    tbl.push_back(rd(B + 32'h32, B + 32'h30, 2'b01));
    tbl.push_back(sq(B + 32'h34, 2'b01, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h30, 2'b01, 1'b1, 2'b00));
    tbl.push_back(sq(B + 32'h34, 2'b01, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h30, 2'b01, 1'b1, 2'b00));
    tbl.push_back(sq(B + 32'h34, 2'b01, 1'b0, 2'b00));
    tbl.push_back(sq(B + 32'h38, 2'b00, 1'b0, 2'b01));
    // Address wrap, then plain preload
    tbl.push_back(rd(32'hFFFF_FFFF, 32'hFFFF_FFFC, 2'b00));
    tbl.push_back(sq(32'h0000_0000, 2'b00, 1'b0, 2'b00));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 32'h800, 2'b00, 1'b0, 2'b00));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Stall at a loop end, then a same-cycle rewrite of the resolving slot
    step(wr(1'b1, 1'b0, 32'h804, 32'h808, 16'd3, 32'h804, 2'b01, 1'b0), "stall_setup");
    step(sq(32'h808, 2'b01, 1'b0, 2'b00), "stall_to_end");
    for (int k = 0; k < 3; k++) begin
      step(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 32'h808, 2'b01, 1'b0, 2'b00),
           $sformatf("stall%0d", k));
    end
    step(wr(1'b1, 1'b0, 32'h804, 32'h808, 16'd5, 32'h804, 2'b01, 1'b1), "override");
    for (int k = 0; k < 4; k++) begin
      step(sq(32'h808, 2'b01, 1'b0, 2'b00), $sformatf("ovr_end%0d", k));
      step(sq(32'h804, 2'b01, 1'b1, 2'b00), $sformatf("ovr_back%0d", k));
    end
    step(sq(32'h808, 2'b01, 1'b0, 2'b00), "ovr_last_end");
    step(sq(32'h80C, 2'b00, 1'b0, 2'b01), "ovr_exit");
    step(wr(1'b0, 1'b1, 32'h900, 32'h904, 16'd1, 32'h80C, 2'b10, 1'b0), "stall_write");

    // Preload with two active loops; a write in the same cycle is dropped
    step(wr(1'b1, 1'b0, 32'h810, 32'h814, 16'd2, 32'h810, 2'b11, 1'b0), "pre_setup");
    step(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h800, 32'h808, 16'd7, 32'h800, 2'b00, 1'b0, 2'b00),
         "preload_mid");

    // Reset mid-loop, at an end where a back-edge would otherwise fire
    step(wr(1'b1, 1'b0, 32'h804, 32'h808, 16'd2, 32'h804, 2'b01, 1'b0), "rst_setup0");
    step(wr(1'b1, 1'b1, 32'h800, 32'h808, 16'd2, 32'h808, 2'b11, 1'b0), "rst_setup1");
    step(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h800, 32'h808, 16'd7, B, 2'b00, 1'b0, 2'b00),
         "rst_mid");
    step(sq(B + 32'h04, 2'b00, 1'b0, 2'b00), "rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the KIRA RISC-V core fetch stage. It holds the architectural fetch PC and selects the next value each cycle from five sources: reset, preload, branch/jump redirect, zero-overhead hardware-loop back-edge, and sequential increment. It owns `LOOPS` independent hardware-loop slots (start, end, count), so software can configure nested loops without branch instructions. It replaces the single-loop next-PC mux and drives the instruction-memory address directly.

## Interface
Parameters:
- `XLEN`, 32, PC and address width.
- `RESET_PC`, 32'h4000_0000, PC value after reset.
- `PRELOAD_PC`, 32'h0000_0800, PC value loaded by `preload`.
- `LOOPS`, 2, number of hardware-loop slots. Slot 0 is the innermost loop. Range is 1..4.
- `CNT_W`, 16, iteration-counter width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  advance enable. When 0, the sequencer stalls.
- `preload`  in  1  force `PRELOAD_PC` and clear all loops.
- `redirect_valid`  in  1  branch/jump taken.
- `redirect_pc`  in  XLEN  branch/jump target (ALU result).
- `lp_wr_valid`  in  1  write one loop slot.
- `lp_wr_idx`  in  $clog2(LOOPS) (min 1)  slot index.
- `lp_wr_start`, `lp_wr_end`  in  XLEN  first and last instruction address of the loop body.
- `lp_wr_count`  in  CNT_W  number of iterations.
- `pc`  out  XLEN  current fetch PC (registered).
- `lp_active`  out  LOOPS  per-slot active flag.
- `lp_back`  out  1  one-cycle pulse: last update was a loop back-edge.
- `lp_done`  out  LOOPS  one-cycle pulse per slot on final-iteration exit.

## Operation
- Per-slot state: `start`, `end`, `count`, `active`. Active means `count != 0`.
- Next-PC priority, evaluated every cycle:
  1. reset
  2. `preload`
  3. `ena == 0`: PC held
  4. `redirect_valid`
  5. loop back-edge
  6. `pc + 4`
- `preload` clears every slot's `count` and `active`, regardless of `ena`.
- `redirect_pc[1:0]` is forced to 2'b00. All other PC arithmetic is modulo 2^XLEN, so `pc + 4` wraps from 0xFFFF_FFFC to 0.
- Back-edge resolution applies when `ena=1` and `redirect_valid=0`. Scan slots from 0 upward, considering only active slots with `end == pc`:
  - If `count > 1`: the slot decrements, next PC = `start`, and the scan stops. `lp_back` pulses.
  - If `count == 1`: the slot goes to 0 and inactive, `lp_done[i]` pulses, and the scan continues to the next matching slot. This allows shared end addresses.
  - If no slot loops back, next PC = `pc + 4`.
- Redirect while `pc` equals an active loop end: redirect wins, and no count changes.
- Loop write: the slot loads start, end and count. `lp_wr_count == 0` writes the slot inactive.
  - A write to a slot that is resolving in the same cycle overrides that slot's decrement or exit. The PC choice from the old slot contents still stands.
  - Writes are accepted when `ena=0`. Writes are ignored during reset and `preload`.
- `lp_wr_start`/`lp_wr_end` low bits are forced to 2'b00.
- `start > end` is not checked. The loop back-edge fires only when `pc == end`.

## Timing
- Reset values: `pc = RESET_PC`, all slots 0 and inactive, `lp_active = 0`, `lp_back = 0`, `lp_done = 0`.
- A `rst_n` low mid-loop has the same effect in the next cycle.
- Latency: the input cycle decides the value, and `pc` shows it at the following `clk` edge. A redirect at cycle t gives `pc = target` at t+1.
- `lp_back` and `lp_done` are registered and aligned with the `pc` update they describe. Both are 0 on stall cycles.
- Stall (`ena=0`): `pc`, all counts and all pulses are frozen or 0. A loop write still lands, and `lp_active` reflects it at the next edge.
- No combinational path exists from any input to any output.

## Structure
- Shared package `kira_pc_pkg`:
  - `lp_slot_t` struct (start, end, count)
  - `PC_INC = 4`
  - the `RESET_PC`/`PRELOAD_PC` defaults
- Sub-module `hwloop_slot`, instantiated `LOOPS` times:
  - holds one slot's registers
  - provides combinational `hit` and `last` outputs, plus decrement/exit/write inputs
- The top level contains the priority scan, PC register and pulse registers.

## Test plan
- **Reset/sequential:** hold `rst_n=0` 2 cycles, then `ena=1` -> `pc` = 0x4000_0000, 0x4000_0004, 0x4000_0008; outputs 0 during reset.
- **Single loop:** write slot0 start 0x4000_0010, end 0x4000_0018, count 3 -> body executes 3 times (`lp_back` pulses 2×). `lp_done[0]` pulses with `pc` = 0x4000_001C, then `lp_active` = 0.
- **Nested, shared end:** slot0 (0x4000_0020..0x4000_0028, count 2) and slot1 (0x4000_0010..0x4000_0028, count 2) -> inner body runs 4 times total. The final exit at 0x4000_0028 pulses `lp_done` = 2'b11 in the same cycle.
- **Redirect vs loop end:** `redirect_valid` with target 0x4000_0103 at `pc` = active end -> `pc` = 0x4000_0100 and count unchanged.
- **Stall and write-override:** `ena=0` for 3 cycles at `pc` = end -> `pc`/count frozen. A same-cycle write of count 5 to the resolving slot makes the count 5, not 4.
- **Preload and reset mid-loop:** `preload` while 2 loops are active -> `pc` = 0x800 and `lp_active` = 0. Repeat with `rst_n=0` -> `pc` = 0x4000_0000 and all slots cleared.
